alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set operand and result width.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 sN_valid  input  1  (N=0,1) SHALL mean requester N presents an operation.
REQ-005 sN_ready  output  1  SHALL mean requester N's operation is accepted this cycle.
REQ-006 sN_alu_op  input  2  SHALL carry the operation class: 00 add, 01 subtract, 10 R-type decode.
REQ-007 sN_funct3  input  3  SHALL carry the R-type funct3.
REQ-008 sN_funct7  input  7  SHALL carry the R-type funct7.
REQ-009 sN_op_a, sN_op_b  input  DATA_WIDTH  SHALL carry operands A and B.
REQ-010 rsp_valid  output  1  SHALL mean the response register holds a result.
REQ-011 rsp_ready  input  1  SHALL mean the consumer takes the response this cycle.
REQ-012 rsp_result  output  DATA_WIDTH  SHALL carry the registered ALU result.
REQ-013 rsp_zero  output  1  SHALL be 1 when rsp_result is all zeros.
REQ-014 rsp_id  output  1  SHALL identify the requester (0/1) that produced rsp_result.

Function
REQ-015 Handshake: a transfer SHALL occur on a port only when valid and ready are both 1 in the same cycle; requesters SHALL hold their payload stable while valid=1 and ready=0.
REQ-016 The response register SHALL be "free" when rsp_valid=0, or when rsp_valid=1 and rsp_ready=1 in the same cycle.
REQ-017 At most one sN_ready SHALL be 1 per cycle, and only while the response register is free.
REQ-018 Grant rule: if only one sN_valid is 1, that port SHALL be granted; if both are 1, the port not granted most recently SHALL be granted.
REQ-019 The last-grant pointer SHALL update only on an accepted transfer.
REQ-020 Latency: an operation accepted in cycle t SHALL appear on rsp_result/rsp_id with rsp_valid=1 in cycle t+1.
REQ-021 A response SHALL be held unchanged while rsp_valid=1 and rsp_ready=0.
REQ-022 rsp_valid SHALL clear after a rsp_ready handshake unless a new operation is accepted in the same cycle.
REQ-023 Back-to-back operation: acceptance plus drain in the same cycle SHALL sustain one result per cycle.
REQ-024 alu_op 00 SHALL produce A+B; alu_op 01 SHALL produce A-B; alu_op 11 SHALL produce 0; all arithmetic SHALL wrap modulo 2^DATA_WIDTH.
REQ-025 alu_op 10 decode: funct3 000 with funct7 0000000 -> A+B; funct3 000 with funct7 0100000 -> A-B; funct3 000 with any other funct7 -> 0.
REQ-026 alu_op 10 decode, continued: funct3 111 AND; 110 OR; 100 XOR; 001 A<<B[4:0]; other funct3 -> 0.
REQ-027 alu_op 10, funct3 101: funct7 0000000 -> logical A>>B[4:0]; any other funct7 -> arithmetic (sign-filling) shift right.
REQ-028 rsp_zero SHALL be computed from the registered result and SHALL never lag it by a cycle.
REQ-029 sN_ready SHALL NOT depend combinationally on sN_valid of the same port beyond the grant rule; rsp_ready may combinationally affect sN_ready.

Reset
REQ-030 While rst_n=0: rsp_valid=0, rsp_result=0, rsp_zero=1, rsp_id=0, s0_ready=0, s1_ready=0.
REQ-031 Reset SHALL set the last-grant pointer to 1, so port 0 wins the first conflict.
REQ-032 Assertion of rst_n mid-operation SHALL discard any held response immediately, with no transfer completed.

Structure
REQ-033 Package alu_pkg SHALL hold the alu_op encodings (ALU_ADD=00, ALU_SUB=01, ALU_RTYPE=10), funct3 codes, and funct7 codes (F7_BASE, F7_ALT).
REQ-034 Combinational decode/compute SHALL live in one sub-module, alu_core (funct3, funct7, alu_op, A, B -> result), instantiated once behind the grant mux.
REQ-035 The arbiter, response register, and pointer SHALL be in alu_arbiter; the target size is 120-250 lines total.

Verification
REQ-036 Single request: s0 add 5+7, rsp_ready=1 -> next cycle rsp_valid=1, rsp_result=12, rsp_id=0, rsp_zero=0.
REQ-037 Conflict after reset: both valid (s0 sub 9-9, s1 XOR) -> s0 granted first with rsp_result=0 and rsp_zero=1; s1 granted the following cycle.
REQ-038 Backpressure: rsp_ready=0 for 3 cycles with a result of 0x10 held -> result stable, both sN_ready=0; with rsp_ready=1 -> next grant in the same cycle.
REQ-039 Shifts: A=0x80000000, B=4, funct3 101: funct7 0 -> 0x08000000; funct7 0100000 -> 0xF8000000.
REQ-040 Illegal encodings: funct3 000 with funct7 0000001 -> result 0; alu_op 11 -> result 0.
REQ-041 Reset mid-stall: rst_n=0 while rsp_valid=1 -> rsp_valid=0 immediately; after release, s0 wins the first conflict.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the arbitrated ALU: operation classes and R-type
// funct3/funct7 codes.
package alu_pkg;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_RTYPE = 2'b10,
    ALU_NONE  = 2'b11
  } alu_op_e;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SR  = 3'b101;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam int SHAMT_W = 5;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: decodes alu_op/funct3/funct7 and computes the
// result; undefined encodings yield zero.
module alu_core
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]            alu_op_i,
  input  logic [2:0]            funct3_i,
  input  logic [6:0]            funct7_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] result_o
);

  logic [SHAMT_W-1:0] shamt;

  assign shamt = b_i[SHAMT_W-1:0];

  // NOTE: result_o gets a default before the case so every path assigns it and no latch is inferred.
  always_comb begin
    result_o = '0;
    case (alu_op_e'(alu_op_i))
      ALU_ADD: result_o = a_i + b_i;
      ALU_SUB: result_o = a_i - b_i;
      ALU_RTYPE: begin
        case (funct3_i)
          F3_ADD: begin
            if (funct7_i == F7_BASE)     result_o = a_i + b_i;
            else if (funct7_i == F7_ALT) result_o = a_i - b_i;
          end
          F3_AND: result_o = a_i & b_i;
          F3_OR:  result_o = a_i | b_i;
          F3_XOR: result_o = a_i ^ b_i;
          F3_SLL: result_o = a_i << shamt;
          F3_SR: begin
            if (funct7_i == F7_BASE) result_o = a_i >> shamt;
            else                     result_o = DATA_WIDTH'($signed(a_i) >>> shamt);
          end
          default: result_o = '0;
        endcase
      end
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared ALU, with a single
// registered response slot that can be drained and refilled in one cycle.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  s0_valid,
  output logic                  s0_ready,
  input  logic [1:0]            s0_alu_op,
  input  logic [2:0]            s0_funct3,
  input  logic [6:0]            s0_funct7,
  input  logic [DATA_WIDTH-1:0] s0_op_a,
  input  logic [DATA_WIDTH-1:0] s0_op_b,

  input  logic                  s1_valid,
  output logic                  s1_ready,
  input  logic [1:0]            s1_alu_op,
  input  logic [2:0]            s1_funct3,
  input  logic [6:0]            s1_funct7,
  input  logic [DATA_WIDTH-1:0] s1_op_a,
  input  logic [DATA_WIDTH-1:0] s1_op_b,

  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_zero,
  output logic                  rsp_id
);

  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic                  rsp_id_q, rsp_id_d;
  logic                  last_q, last_d;

  logic                  rsp_free;
  logic                  gnt0, gnt1, accept;
  logic [1:0]            sel_alu_op;
  logic [2:0]            sel_funct3;
  logic [6:0]            sel_funct7;
  logic [DATA_WIDTH-1:0] sel_a, sel_b, core_result;

  // The slot is free when empty or being drained this cycle; grants are
  // suppressed during reset so neither requester sees a phantom accept.
  assign rsp_free = !rsp_valid_q || rsp_ready;
  assign gnt0     = rst_n && rsp_free && s0_valid && (!s1_valid || last_q);
  assign gnt1     = rst_n && rsp_free && s1_valid && (!s0_valid || !last_q);
  assign accept   = gnt0 || gnt1;

  assign s0_ready = gnt0;
  assign s1_ready = gnt1;

  assign sel_alu_op = gnt1 ? s1_alu_op : s0_alu_op;
  assign sel_funct3 = gnt1 ? s1_funct3 : s0_funct3;
  assign sel_funct7 = gnt1 ? s1_funct7 : s0_funct7;
  assign sel_a      = gnt1 ? s1_op_a   : s0_op_a;
  assign sel_b      = gnt1 ? s1_op_b   : s0_op_b;

  alu_core #(.DATA_WIDTH(DATA_WIDTH)) u_core (
    .alu_op_i (sel_alu_op),
    .funct3_i (sel_funct3),
    .funct7_i (sel_funct7),
    .a_i      (sel_a),
    .b_i      (sel_b),
    .result_o (core_result)
  );

  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_id_d     = rsp_id_q;
    last_d       = last_q;
    if (accept) begin
      rsp_valid_d  = 1'b1;
      rsp_result_d = core_result;
      rsp_id_d     = gnt1;
      last_d       = gnt1;
    end else if (rsp_ready) begin
      rsp_valid_d  = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_id_q     <= 1'b0;
      last_q       <= 1'b1;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_id_q     <= rsp_id_d;
      last_q       <= last_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_zero   = (rsp_result_q == '0);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus a randomized
// run scored against a behavioural model of arbitration and ALU rules.
module tb_alu_arbiter;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s0_valid, s0_ready, s1_valid, s1_ready;
  logic [1:0]    s0_alu_op, s1_alu_op;
  logic [2:0]    s0_funct3, s1_funct3;
  logic [6:0]    s0_funct7, s1_funct7;
  logic [DW-1:0] s0_op_a, s0_op_b, s1_op_a, s1_op_b;
  logic          rsp_valid, rsp_ready, rsp_zero, rsp_id;
  logic [DW-1:0] rsp_result;

  int checks   = 0;
  int failures = 0;

  alu_arbiter #(.DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s0_valid   (s0_valid),
    .s0_ready   (s0_ready),
    .s0_alu_op  (s0_alu_op),
    .s0_funct3  (s0_funct3),
    .s0_funct7  (s0_funct7),
    .s0_op_a    (s0_op_a),
    .s0_op_b    (s0_op_b),
    .s1_valid   (s1_valid),
    .s1_ready   (s1_ready),
    .s1_alu_op  (s1_alu_op),
    .s1_funct3  (s1_funct3),
    .s1_funct7  (s1_funct7),
    .s1_op_a    (s1_op_a),
    .s1_op_b    (s1_op_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_id     (rsp_id)
  );

  always #5 clk = ~clk;

  // Reference ALU written straight from the operation table.
  function automatic logic [31:0] alu_ref(input logic [1:0] op, input logic [2:0] f3,
                                          input logic [6:0] f7, input logic [31:0] a,
                                          input logic [31:0] b);
    int          sh;
    logic [31:0] ones;
    sh   = int'(b & 32'h1f);
    ones = 32'hffff_ffff;
    if (op == 2'd0) return a + b;
    if (op == 2'd1) return a - b;
    if (op == 2'd3) return 32'd0;
    case (f3)
      3'd0: begin
        if (f7 == 7'd0)  return a + b;
        if (f7 == 7'h20) return a - b;
        return 32'd0;
      end
      3'd7: return a & b;
      3'd6: return a | b;
      3'd4: return a ^ b;
      3'd1: return a << sh;
      3'd5: begin
        if (f7 == 7'd0) return a >> sh;
        return (a >> sh) | (a[31] ? ~(ones >> sh) : 32'd0);
      end
      default: return 32'd0;
    endcase
  endfunction

  task automatic set_s0(input logic v, input logic [1:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b);
    s0_valid = v; s0_alu_op = op; s0_funct3 = f3; s0_funct7 = f7; s0_op_a = a; s0_op_b = b;
  endtask

  task automatic set_s1(input logic v, input logic [1:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b);
    s1_valid = v; s1_alu_op = op; s1_funct3 = f3; s1_funct7 = f7; s1_op_a = a; s1_op_b = b;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; s0_valid = 1'b0; s1_valid = 1'b0; rsp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    set_s0(1'b1, 2'd0, 3'd0, 7'd0, 32'd1, 32'd2);
    set_s1(1'b1, 2'd0, 3'd0, 7'd0, 32'd3, 32'd4);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({rsp_valid, rsp_id, rsp_zero, s0_ready, s1_ready} !== 5'b00100 || rsp_result !== 32'd0) begin
      failures++;
      $display("FAIL reset_state: got v=%b id=%b z=%b r0=%b r1=%b res=%h, want v=0 id=0 z=1 r0=0 r1=0 res=0",
               rsp_valid, rsp_id, rsp_zero, s0_ready, s1_ready, rsp_result);
    end
    @(negedge clk);
    s0_valid = 1'b0; s1_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    set_s0(1'b1, 2'd0, 3'd0, 7'd0, 32'd5, 32'd7);
    s1_valid = 1'b0; rsp_ready = 1'b1;
    #1;
    checks++;
    if (s0_ready !== 1'b1 || s1_ready !== 1'b0) begin
      failures++;
      $display("FAIL single_ready: got r0=%b r1=%b, want r0=1 r1=0", s0_ready, s1_ready);
    end
    @(posedge clk); #1;
    checks++;
    if ({rsp_valid, rsp_id, rsp_zero} !== 3'b100 || rsp_result !== 32'd12) begin
      failures++;
      $display("FAIL single_rsp: got v=%b id=%b z=%b res=%h, want v=1 id=0 z=0 res=0000000c",
               rsp_valid, rsp_id, rsp_zero, rsp_result);
    end
    @(negedge clk);
    s0_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_drain: got v=%b, want v=0", rsp_valid);
    end
  endtask

  task automatic test_conflict();
    do_reset();
    set_s0(1'b1, 2'd1, 3'd0, 7'd0, 32'd9, 32'd9);
    set_s1(1'b1, 2'd2, 3'd4, 7'd0, 32'h0000_f0f0, 32'h0000_0ff0);
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (s0_ready !== 1'b1 || s1_ready !== 1'b0) begin
      failures++;
      $display("FAIL conflict_first_grant: got r0=%b r1=%b, want r0=1 r1=0", s0_ready, s1_ready);
    end
    @(posedge clk); #1;
    checks++;
    if ({rsp_valid, rsp_id, rsp_zero} !== 3'b101 || rsp_result !== 32'd0) begin
      failures++;
      $display("FAIL conflict_s0_rsp: got v=%b id=%b z=%b res=%h, want v=1 id=0 z=1 res=0",
               rsp_valid, rsp_id, rsp_zero, rsp_result);
    end
    @(negedge clk);
    s0_valid = 1'b0;
    #1;
    checks++;
    if (s0_ready !== 1'b0 || s1_ready !== 1'b1) begin
      failures++;
      $display("FAIL conflict_second_grant: got r0=%b r1=%b, want r0=0 r1=1", s0_ready, s1_ready);
    end
    @(posedge clk); #1;
    checks++;
    if ({rsp_valid, rsp_id, rsp_zero} !== 3'b110 || rsp_result !== 32'h0000_ff00) begin
      failures++;
      $display("FAIL conflict_s1_rsp: got v=%b id=%b z=%b res=%h, want v=1 id=1 z=0 res=0000ff00",
               rsp_valid, rsp_id, rsp_zero, rsp_result);
    end
    @(negedge clk);
    s1_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    set_s0(1'b1, 2'd0, 3'd0, 7'd0, 32'd8, 32'd8);
    s1_valid = 1'b0; rsp_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    set_s0(1'b1, 2'd0, 3'd0, 7'd0, 32'd1, 32'd2);
    set_s1(1'b1, 2'd1, 3'd0, 7'd0, 32'd100, 32'd1);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (s0_ready !== 1'b0 || s1_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall_ready[%0d]: got r0=%b r1=%b, want r0=0 r1=0", i, s0_ready, s1_ready);
      end
      @(posedge clk); #1;
      checks++;
      if ({rsp_valid, rsp_id} !== 2'b10 || rsp_result !== 32'h10) begin
        failures++;
        $display("FAIL stall_hold[%0d]: got v=%b id=%b res=%h, want v=1 id=0 res=00000010",
                 i, rsp_valid, rsp_id, rsp_result);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (s0_ready !== 1'b0 || s1_ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_release_grant: got r0=%b r1=%b, want r0=0 r1=1", s0_ready, s1_ready);
    end
    @(posedge clk); #1;
    checks++;
    if ({rsp_valid, rsp_id} !== 2'b11 || rsp_result !== 32'd99) begin
      failures++;
      $display("FAIL stall_release_rsp: got v=%b id=%b res=%h, want v=1 id=1 res=00000063",
               rsp_valid, rsp_id, rsp_result);
    end
    @(negedge clk);
    s1_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({rsp_valid, rsp_id} !== 2'b10 || rsp_result !== 32'd3) begin
      failures++;
      $display("FAIL b2b_next_rsp: got v=%b id=%b res=%h, want v=1 id=0 res=00000003",
               rsp_valid, rsp_id, rsp_result);
    end
    @(negedge clk);
    s0_valid = 1'b0;
  endtask

  task automatic test_shifts_and_illegal();
    logic [1:0]  ops[6] = '{2'd2, 2'd2, 2'd0, 2'd2, 2'd2, 2'd3};
    logic [2:0]  f3s[6] = '{3'd5, 3'd5, 3'd0, 3'd0, 3'd1, 3'd0};
    logic [6:0]  f7s[6] = '{7'h00, 7'h20, 7'h00, 7'h01, 7'h00, 7'h00};
    logic [31:0] as[6]  = '{32'h8000_0000, 32'h8000_0000, 32'd3, 32'd3, 32'h0000_0001, 32'h1234};
    logic [31:0] bs[6]  = '{32'd4, 32'd4, 32'd4, 32'd4, 32'h0000_0024, 32'h5678};
    logic [31:0] want[6] = '{32'h0800_0000, 32'hf800_0000, 32'd7, 32'd0, 32'h0000_0010, 32'd0};
    do_reset();
    s1_valid = 1'b0; rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_s0(1'b1, ops[i], f3s[i], f7s[i], as[i], bs[i]);
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== want[i] || rsp_zero !== (want[i] == 32'd0)) begin
        failures++;
        $display("FAIL decode[%0d]: got v=%b res=%h z=%b, want v=1 res=%h z=%b",
                 i, rsp_valid, rsp_result, rsp_zero, want[i], want[i] == 32'd0);
      end
      @(negedge clk);
    end
    s0_valid = 1'b0;
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    set_s0(1'b1, 2'd0, 3'd0, 7'd0, 32'd1, 32'd1);
    s1_valid = 1'b0; rsp_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    set_s1(1'b1, 2'd0, 3'd0, 7'd0, 32'd2, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rsp_valid, rsp_id, rsp_zero, s0_ready, s1_ready} !== 5'b00100 || rsp_result !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid_stall: got v=%b id=%b z=%b r0=%b r1=%b res=%h, want v=0 id=0 z=1 r0=0 r1=0 res=0",
               rsp_valid, rsp_id, rsp_zero, s0_ready, s1_ready, rsp_result);
    end
    @(negedge clk);
    rst_n = 1'b1; rsp_ready = 1'b1;
    #1;
    checks++;
    if (s0_ready !== 1'b1 || s1_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_conflict_grant: got r0=%b r1=%b, want r0=1 r1=0", s0_ready, s1_ready);
    end
    @(posedge clk); #1;
    checks++;
    if ({rsp_valid, rsp_id} !== 2'b10 || rsp_result !== 32'd2) begin
      failures++;
      $display("FAIL reset_conflict_rsp: got v=%b id=%b res=%h, want v=1 id=0 res=00000002",
               rsp_valid, rsp_id, rsp_result);
    end
    @(negedge clk);
    s0_valid = 1'b0; s1_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_operand(input logic [31:0] other);
    case ($urandom_range(0, 4))
      0:       return 32'd0;
      1:       return other;
      2:       return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [6:0] rand_funct7();
    case ($urandom_range(0, 2))
      0:       return 7'h00;
      1:       return 7'h20;
      default: return 7'($urandom);
    endcase
  endfunction

  task automatic test_random();
    bit          t0 = 1'b0, t1 = 1'b0;
    bit          m_valid = 1'b0, free;
    int          m_id = 0, m_last = 1, win;
    logic [31:0] m_result = 32'd0;
    do_reset();
    for (int cyc = 0; cyc < 500; cyc++) begin
      if (cyc != 0) @(negedge clk);
      if (!s0_valid || t0) begin
        s0_valid = ($urandom_range(0, 3) != 0);
        s0_alu_op = 2'($urandom); s0_funct3 = 3'($urandom); s0_funct7 = rand_funct7();
        s0_op_a = $urandom; s0_op_b = rand_operand(s0_op_a);
      end
      if (!s1_valid || t1) begin
        s1_valid = ($urandom_range(0, 3) != 0);
        s1_alu_op = 2'($urandom); s1_funct3 = 3'($urandom); s1_funct7 = rand_funct7();
        s1_op_a = $urandom; s1_op_b = rand_operand(s1_op_a);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      free = !m_valid || rsp_ready;
      win  = -1;
      if (free) begin
        if (s0_valid && s1_valid) win = 1 - m_last;
        else if (s0_valid)        win = 0;
        else if (s1_valid)        win = 1;
      end
      checks++;
      if (s0_ready !== (win == 0) || s1_ready !== (win == 1)) begin
        failures++;
        $display("FAIL rand_grant[%0d]: got r0=%b r1=%b, want r0=%b r1=%b",
                 cyc, s0_ready, s1_ready, win == 0, win == 1);
      end
      t0 = (win == 0);
      t1 = (win == 1);
      if (win == 0) begin
        m_result = alu_ref(s0_alu_op, s0_funct3, s0_funct7, s0_op_a, s0_op_b);
        m_valid = 1'b1; m_id = 0; m_last = 0;
      end else if (win == 1) begin
        m_result = alu_ref(s1_alu_op, s1_funct3, s1_funct7, s1_op_a, s1_op_b);
        m_valid = 1'b1; m_id = 1; m_last = 1;
      end else if (rsp_ready) begin
        m_valid = 1'b0;
      end
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== m_valid || rsp_result !== m_result || rsp_zero !== (m_result == 32'd0) ||
          (m_valid && rsp_id !== m_id[0])) begin
        failures++;
        $display("FAIL rand_rsp[%0d]: got v=%b id=%b z=%b res=%h, want v=%b id=%0d z=%b res=%h",
                 cyc, rsp_valid, rsp_id, rsp_zero, rsp_result, m_valid, m_id, m_result == 32'd0, m_result);
      end
    end
    @(negedge clk);
    s0_valid = 1'b0; s1_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b0;
    set_s0(1'b0, 2'd0, 3'd0, 7'd0, 32'd0, 32'd0);
    set_s1(1'b0, 2'd0, 3'd0, 7'd0, 32'd0, 32'd0);
    test_reset();
    test_single();
    test_conflict();
    test_backpressure();
    test_shifts_and_illegal();
    test_reset_mid_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
